// File: rtl/fp_operand_aligner.sv
// fp_operand_aligner
// Exponent-alignment stage of the FPU add/sub path. Two IEEE-754 operands
// are accepted over a valid/ready handshake and ordered by magnitude. The
// smaller mantissa is then shifted right one bit per cycle, keeping
// guard/round/sticky bits, until it sits at the larger exponent.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   in_valid, in_ready    operand handshake (in_ready high only in IDLE)
//   a, b                  operands {sign, exp, frac}
//   out_valid, out_ready  result handshake
//   sign_big, sign_small  signs of the larger / smaller magnitude operand
//   exp_out               common (larger) effective exponent
//   man_big, man_small    {hidden, frac, guard bits}; man_small bit 0 is sticky
//   swapped               B strictly larger in magnitude than A
//   special               either exponent all ones (Inf/NaN)
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// COMPARE | order operands, load mantissas, pick shift path
// SHIFT   | shift small mantissa one bit per cycle
// DONE    | present result until out_ready
module fp_operand_aligner #(
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int GUARD_BITS = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sign_big,
  output logic                           sign_small,
  output logic [EXP_WIDTH-1:0]           exp_out,
  output logic [MAN_WIDTH+GUARD_BITS:0]  man_big,
  output logic [MAN_WIDTH+GUARD_BITS:0]  man_small,
  output logic                           swapped,
  output logic                           special
);

  localparam int W   = MAN_WIDTH + 1 + GUARD_BITS;
  localparam int OPW = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic [EXP_WIDTH:0] W_D = (EXP_WIDTH+1)'(W);

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

  state_t               state;
  logic [OPW-1:0]       a_q, b_q;
  logic [EXP_WIDTH:0]   cnt;

  logic [EXP_WIDTH-1:0] a_exp, b_exp, a_eff, b_eff;
  logic [EXP_WIDTH-1:0] exp_big_eff, exp_small_eff;
  logic [W-1:0]         a_man, b_man, man_big_n, man_small_n, shift_next;
  logic [EXP_WIDTH:0]   diff;
  logic                 b_gt_a, is_special;

  assign a_exp = a_q[OPW-2 -: EXP_WIDTH];
  assign b_exp = b_q[OPW-2 -: EXP_WIDTH];
  // Zeros and denormals share effective exponent 1 (hidden bit 0).
  assign a_eff = (a_exp == '0) ? EXP_WIDTH'(1) : a_exp;
  assign b_eff = (b_exp == '0) ? EXP_WIDTH'(1) : b_exp;
  assign a_man = {|a_exp, a_q[MAN_WIDTH-1:0], {GUARD_BITS{1'b0}}};
  assign b_man = {|b_exp, b_q[MAN_WIDTH-1:0], {GUARD_BITS{1'b0}}};

  // {exp,frac} compares as an unsigned magnitude; ties keep A as big.
  assign b_gt_a        = b_q[OPW-2:0] > a_q[OPW-2:0];
  assign exp_big_eff   = b_gt_a ? b_eff : a_eff;
  assign exp_small_eff = b_gt_a ? a_eff : b_eff;
  assign man_big_n     = b_gt_a ? b_man : a_man;
  assign man_small_n   = b_gt_a ? a_man : b_man;
  assign diff          = {1'b0, exp_big_eff} - {1'b0, exp_small_eff};
  assign is_special    = (&a_exp) | (&b_exp);

  // Bits shifted out are folded into the sticky LSB.
  assign shift_next = {1'b0, man_small[W-1:2], man_small[1] | man_small[0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      exp_out    <= '0;
      man_big    <= '0;
      man_small  <= '0;
      swapped    <= 1'b0;
      special    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            in_ready <= 1'b0;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          sign_big   <= b_gt_a ? b_q[OPW-1] : a_q[OPW-1];
          sign_small <= b_gt_a ? a_q[OPW-1] : b_q[OPW-1];
          swapped    <= b_gt_a;
          special    <= is_special;
          man_big    <= man_big_n;
          if (is_special) begin
            man_small <= man_small_n;
            exp_out   <= '1;
            state     <= DONE;
          end else begin
            exp_out <= exp_big_eff;
            if (diff == '0) begin
              man_small <= man_small_n;
              state     <= DONE;
            end else if (diff >= W_D) begin
              man_small <= {{(W-1){1'b0}}, |man_small_n};
              state     <= DONE;
            end else begin
              man_small <= man_small_n;
              cnt       <= diff;
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          man_small <= shift_next;
          cnt       <= cnt - 1'b1;
          if (cnt == (EXP_WIDTH+1)'(1)) state <= DONE;
        end
        DONE: begin
          // out_valid is registered, so it rises one edge after DONE is entered.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_operand_aligner.sv
// Directed testbench for fp_operand_aligner with hand-computed expectations.
module tb_fp_operand_aligner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_big, sign_small;
  logic [7:0]  exp_out;
  logic [26:0] man_big, man_small;
  logic        swapped, special;

  int checks = 0;
  int errors = 0;
  int lat;

  fp_operand_aligner dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_big(sign_big), .sign_small(sign_small), .exp_out(exp_out),
    .man_big(man_big), .man_small(man_small),
    .swapped(swapped), .special(special)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents operands for one accepting edge (edge T), returns at T+1ns.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v);
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Number of edges after T until out_valid is seen high; -1 on timeout.
  task automatic wait_valid(output int l);
    l = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exp_out", exp_out, 0);
    chk("rst_man_small", man_small, 0);
    reset = 1'b1;

    // equal operands
    send(32'h3F800000, 32'h3F800000);
    chk("eq_in_ready_busy", in_ready, 0);
    wait_valid(lat);
    chk("eq_lat", lat, 2);
    chk("eq_swapped", swapped, 0);
    chk("eq_exp", exp_out, 8'h7F);
    chk("eq_man_big", man_big, 27'h4000000);
    chk("eq_man_small", man_small, 27'h4000000);
    drain();
    chk("eq_drain_valid", out_valid, 0);
    chk("eq_drain_ready", in_ready, 1);

    // d=1
    send(32'h3F800000, 32'h3F000000);
    wait_valid(lat);
    chk("d1_lat", lat, 3);
    chk("d1_swapped", swapped, 0);
    chk("d1_man_big", man_big, 27'h4000000);
    chk("d1_man_small", man_small, 27'h2000000);
    drain();

    // d=1 swapped
    send(32'h3F000000, 32'h3F800000);
    wait_valid(lat);
    chk("d1s_lat", lat, 3);
    chk("d1s_swapped", swapped, 1);
    chk("d1s_man_big", man_big, 27'h4000000);
    chk("d1s_man_small", man_small, 27'h2000000);
    drain();

    // d=24 sticky, negative small operand
    send(32'h3F800000, 32'hB3800001);
    wait_valid(lat);
    chk("stk_lat", lat, 26);
    chk("stk_man_small", man_small, 27'h0000005);
    chk("stk_sign_small", sign_small, 1);
    chk("stk_sign_big", sign_big, 0);
    chk("stk_exp", exp_out, 8'h7F);
    drain();

    // d>=W cap with nonzero small
    send(32'h3F800000, 32'h00800000);
    wait_valid(lat);
    chk("cap_lat", lat, 2);
    chk("cap_man_small", man_small, 27'h0000001);
    chk("cap_exp", exp_out, 8'h7F);
    drain();

    // zero small operand
    send(32'h3F800000, 32'h00000000);
    wait_valid(lat);
    chk("zero_lat", lat, 2);
    chk("zero_man_small", man_small, 27'h0000000);
    drain();

    // special with back-pressure
    send(32'h7F800000, 32'h3F800000);
    wait_valid(lat);
    chk("sp_lat", lat, 2);
    chk("sp_special", special, 1);
    chk("sp_exp", exp_out, 8'hFF);
    chk("sp_man_big", man_big, 27'h4000000);
    chk("sp_man_small", man_small, 27'h4000000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_exp", exp_out, 8'hFF);
      chk("bp_special", special, 1);
      chk("bp_man_small", man_small, 27'h4000000);
    end
    drain();
    chk("sp_drain_valid", out_valid, 0);
    chk("sp_drain_ready", in_ready, 1);

    // reset during a d=10 shift
    send(32'h3F800000, 32'h3A800000);
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_man_small", man_small, 0);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("mr_no_leftover", out_valid, 0);

    send(32'h3F000000, 32'h3F800000);
    wait_valid(lat);
    chk("post_lat", lat, 3);
    chk("post_swapped", swapped, 1);
    chk("post_man_small", man_small, 27'h2000000);
    chk("post_exp", exp_out, 8'h7F);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
